// File: rtl/fixed_accum_pkg.sv
// Shared fixed-point definitions: default widths and the accumulator state encoding.
package fixed_accum_pkg;

  localparam int unsigned DATA_W_DEF = 44;
  localparam int unsigned ACC_W_DEF  = 48;
  localparam int unsigned CNT_W_DEF  = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/sat_add.sv
// Combinational signed add of an ACC_W accumulator and an (ACC_W+1)-bit operand,
// clamped to the ACC_W signed range with an overflow flag.
module sat_add #(
  parameter int unsigned ACC_W = 48
) (
  input  logic signed [ACC_W-1:0] a,
  input  logic signed [ACC_W:0]   b,
  output logic signed [ACC_W-1:0] sum_c,
  output logic                    ovf_c
);

  localparam int unsigned SUM_W = ACC_W + 2;

  logic signed [SUM_W-1:0] full_c;
  logic [2:0]              top_c;

  assign full_c = SUM_W'(a) + SUM_W'(b);
  assign top_c  = full_c[SUM_W-1:ACC_W-1];

  // The result fits only when the sign bit and both guard bits agree.
  always_comb begin
    sum_c = full_c[ACC_W-1:0];
    ovf_c = 1'b0;
    if (!((&top_c) || (~|top_c))) begin
      ovf_c = 1'b1;
      sum_c = full_c[SUM_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                              : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/fixed_accum.sv
// Saturating accumulator: sums len signed fixed-point beats and holds the result
// until the consumer takes it.
module fixed_accum
  import fixed_accum_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_ovf
);

  state_e                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    ovf_q, ovf_d;
  logic                    in_ready_q, in_ready_d;
  logic                    out_valid_q, out_valid_d;

  logic signed [ACC_W:0]   ext_data_c;
  logic signed [ACC_W-1:0] sum_c;
  logic                    sat_c;

  assign ext_data_c = (ACC_W+1)'($signed(in_data));

  sat_add #(.ACC_W(ACC_W)) u_sat_add (
    .a     (acc_q),
    .b     (ext_data_c),
    .sum_c (sum_c),
    .ovf_c (sat_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Abort wins over everything; the handshake flags follow the next state.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (abort) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            acc_d   = '0;
            ovf_d   = 1'b0;
            cnt_d   = len;
            state_d = (len == '0) ? HOLD : ACCUM;
          end
        end
        ACCUM: begin
          if (in_valid && in_ready_q) begin
            acc_d = sum_c;
            ovf_d = ovf_q | sat_c;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_d = IDLE;
            acc_d   = '0;
            ovf_d   = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    in_ready_d  = (state_d == ACCUM);
    out_valid_d = (state_d == HOLD);
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = acc_q;
  assign out_ovf   = ovf_q;

endmodule
